// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: captures one record per retired instruction and drains them over valid/ready.
// Never stalls the core; overflow drops records and is reported through trace_seq gaps, a sticky flag and counters.
// Optional macro TRACE_TIMESTAMP_EN stores a free-running cycle stamp with each record (trace_timestamp).
module commit_trace_buffer #(
   parameter int DEPTH      = 16,
   parameter int DROP_CNT_W = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      commit_valid,
   input  logic [31:0]               commit_pc,
   input  logic [31:0]               commit_instr,
   input  logic [4:0]                commit_rd,
   input  logic [31:0]               commit_data,
   output logic                      trace_valid,
   input  logic                      trace_ready,
   output logic [31:0]               trace_pc,
   output logic [31:0]               trace_instr,
   output logic [4:0]                trace_rd,
   output logic [31:0]               trace_data,
   output logic [15:0]               trace_seq,
`ifdef TRACE_TIMESTAMP_EN
   output logic [31:0]               trace_timestamp,
`endif
   input  logic                      flush,
   input  logic                      clear_stats,
   output logic                      overflow,
   output logic [DROP_CNT_W-1:0]     drop_count,
   output logic [63:0]               retired_count,
   output logic [$clog2(DEPTH):0]    fill_level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]           PTR_ONE  = 1;
   localparam logic [DROP_CNT_W-1:0] DROP_ONE = 1;

   logic [AW:0]           wr_ptr_q, wr_ptr_d;
   logic [AW:0]           rd_ptr_q, rd_ptr_d;
   logic [15:0]           seq_q, seq_d;
   logic                  overflow_q, overflow_d;
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic [63:0]           retired_q, retired_d;

   logic [31:0] pc_mem    [DEPTH];
   logic [31:0] instr_mem [DEPTH];
   logic [4:0]  rd_mem    [DEPTH];
   logic [31:0] data_mem  [DEPTH];
   logic [15:0] seq_mem   [DEPTH];

   logic          full;
   logic          empty;
   logic          pop;
   logic          push;
   logic          drop;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] rd_idx;

   assign wr_idx = wr_ptr_q[AW-1:0];
   assign rd_idx = rd_ptr_q[AW-1:0];
   assign empty  = (wr_ptr_q == rd_ptr_q);
   assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

   // A pop frees the head slot this cycle, so a full FIFO can still take the commit.
   assign pop  = !empty && trace_ready && !flush;
   assign push = commit_valid && !flush && (!full || pop);
   assign drop = commit_valid && !flush && full && !pop;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      seq_d      = seq_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      retired_d  = retired_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      end

      if (commit_valid) seq_d = seq_q + 16'd1;

      if (clear_stats) begin
         overflow_d = 1'b0;
         drop_cnt_d = '0;
         retired_d  = '0;
      end else begin
         if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != {DROP_CNT_W{1'b1}}) drop_cnt_d = drop_cnt_q + DROP_ONE;
         end
         if (commit_valid) retired_d = retired_q + 64'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         seq_q      <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
         retired_q  <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         seq_q      <= seq_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
         retired_q  <= retired_d;
      end
   end

   // Record storage is not reset; stale entries are hidden by gating the outputs with trace_valid.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_idx]    <= commit_pc;
         instr_mem[wr_idx] <= commit_instr;
         rd_mem[wr_idx]    <= commit_rd;
         data_mem[wr_idx]  <= commit_data;
         seq_mem[wr_idx]   <= seq_q;
      end
   end

   assign trace_valid   = !empty;
   assign trace_pc      = trace_valid ? pc_mem[rd_idx]    : '0;
   assign trace_instr   = trace_valid ? instr_mem[rd_idx] : '0;
   assign trace_rd      = trace_valid ? rd_mem[rd_idx]    : '0;
   assign trace_data    = trace_valid ? data_mem[rd_idx]  : '0;
   assign trace_seq     = trace_valid ? seq_mem[rd_idx]   : '0;
   assign overflow      = overflow_q;
   assign drop_count    = drop_cnt_q;
   assign retired_count = retired_q;
   assign fill_level    = wr_ptr_q - rd_ptr_q;

`ifdef TRACE_TIMESTAMP_EN
   logic [31:0] ts_q, ts_d;
   logic [31:0] ts_mem [DEPTH];

   assign ts_d = ts_q + 32'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ts_q <= '0;
      else        ts_q <= ts_d;
   end

   always_ff @(posedge clk) begin
      if (push) ts_mem[wr_idx] <= ts_q;
   end

   assign trace_timestamp = trace_valid ? ts_mem[rd_idx] : '0;
`endif

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: directed scenarios plus randomized traffic against a queue model.
`timescale 1ns/1ps
module tb_commit_trace_buffer;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        commit_valid = 1'b0;
   logic [31:0] commit_pc = '0;
   logic [31:0] commit_instr = '0;
   logic [4:0]  commit_rd = '0;
   logic [31:0] commit_data = '0;
   logic        trace_valid;
   logic        trace_ready = 1'b0;
   logic [31:0] trace_pc;
   logic [31:0] trace_instr;
   logic [4:0]  trace_rd;
   logic [31:0] trace_data;
   logic [15:0] trace_seq;
`ifdef TRACE_TIMESTAMP_EN
   logic [31:0] trace_timestamp;
`endif
   logic        flush = 1'b0;
   logic        clear_stats = 1'b0;
   logic        overflow;
   logic [15:0] drop_count;
   logic [63:0] retired_count;
   logic [4:0]  fill_level;

   int n_pass = 0;
   int n_chk  = 0;

   commit_trace_buffer #(.DEPTH(DEPTH), .DROP_CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
      .commit_rd(commit_rd), .commit_data(commit_data),
      .trace_valid(trace_valid), .trace_ready(trace_ready),
      .trace_pc(trace_pc), .trace_instr(trace_instr), .trace_rd(trace_rd),
      .trace_data(trace_data), .trace_seq(trace_seq),
`ifdef TRACE_TIMESTAMP_EN
      .trace_timestamp(trace_timestamp),
`endif
      .flush(flush), .clear_stats(clear_stats),
      .overflow(overflow), .drop_count(drop_count),
      .retired_count(retired_count), .fill_level(fill_level)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [15:0] seq;
   } rec_t;

   rec_t        mq[$];
   logic [15:0] m_seq;
   logic        m_ovf;
   logic [15:0] m_drop;
   logic [63:0] m_ret;

   function automatic void model_reset();
      mq.delete();
      m_seq  = '0;
      m_ovf  = 1'b0;
      m_drop = '0;
      m_ret  = '0;
   endfunction

   // Applies the current inputs to the model as the upcoming clock edge will.
   function automatic void model_edge();
      rec_t r;
      bit   was_full;
      bit   do_pop;
      if (!rst_n) begin
         model_reset();
         return;
      end
      was_full = (mq.size() == DEPTH);
      do_pop   = (mq.size() > 0) && trace_ready && !flush;
      if (flush) begin
         mq.delete();
      end else begin
         if (do_pop) void'(mq.pop_front());
         if (commit_valid) begin
            if (!was_full || do_pop) begin
               r.pc = commit_pc; r.instr = commit_instr; r.rd = commit_rd;
               r.data = commit_data; r.seq = m_seq;
               mq.push_back(r);
            end else begin
               m_ovf = 1'b1;
               if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end
         end
      end
      if (commit_valid) m_ret = m_ret + 64'd1;
      if (clear_stats) begin
         m_ovf = 1'b0; m_drop = '0; m_ret = '0;
      end
      if (commit_valid) m_seq = m_seq + 16'd1;
   endfunction

   function automatic logic [$bits(rec_t):0] dut_head();
      rec_t r;
      r.pc = trace_pc; r.instr = trace_instr; r.rd = trace_rd;
      r.data = trace_data; r.seq = trace_seq;
      if (!trace_valid) r = '0;
      return {trace_valid, r};
   endfunction

   function automatic logic [$bits(rec_t):0] exp_head();
      if (mq.size() == 0) return '0;
      return {1'b1, mq[0]};
   endfunction

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      commit_valid = 1'b0;
      flush        = 1'b0;
      clear_stats  = 1'b0;
   endtask

   task automatic commit(input logic [31:0] pc, input logic [31:0] instr,
                         input logic [4:0] rd, input logic [31:0] data);
      commit_valid = 1'b1;
      commit_pc    = pc;
      commit_instr = instr;
      commit_rd    = rd;
      commit_data  = data;
   endtask

   task automatic do_reset();
      idle();
      trace_ready = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      tick();
      tick();
      n_chk++;
      if ({trace_valid, trace_pc, trace_instr, trace_rd, trace_data, trace_seq,
           overflow, drop_count, retired_count, fill_level} !== '0)
         $display("FAIL reset_outputs: got valid=%b fill=%0d ret=%0d drop=%0d ovf=%b want all zero",
                  trace_valid, fill_level, retired_count, drop_count, overflow);
      else n_pass++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_record();
      do_reset();
      trace_ready = 1'b1;
      commit(32'h0000_0010, 32'h0050_0093, 5'd1, 32'd5);
      tick();
      idle();
      n_chk++;
      if (dut_head() !== {1'b1, 32'h0000_0010, 32'h0050_0093, 5'd1, 32'd5, 16'd0})
         $display("FAIL single_head: got %h want %h", dut_head(),
                  {1'b1, 32'h0000_0010, 32'h0050_0093, 5'd1, 32'd5, 16'd0});
      else n_pass++;
      tick();
      n_chk++;
      if ({trace_valid, retired_count} !== {1'b0, 64'd1})
         $display("FAIL single_after: got valid=%b ret=%0d want valid=0 ret=1", trace_valid, retired_count);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         commit(32'(i * 4), 32'h13, 5'd0, 32'd0);
         tick();
      end
      idle();
      n_chk++;
      if ({fill_level, trace_pc} !== {5'd3, 32'h0})
         $display("FAIL bp_fill: got fill=%0d pc=%h want fill=3 pc=0", fill_level, trace_pc);
      else n_pass++;
      tick();
      n_chk++;
      if ({trace_valid, trace_pc, trace_seq} !== {1'b1, 32'h0, 16'd0})
         $display("FAIL bp_hold: got valid=%b pc=%h seq=%0d want 1/0/0", trace_valid, trace_pc, trace_seq);
      else n_pass++;
      trace_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_chk++;
         if ({trace_valid, trace_pc, trace_seq} !== {1'b1, 32'(i * 4), 16'(i)})
            $display("FAIL bp_drain: got valid=%b pc=%h seq=%0d want pc=%h seq=%0d",
                     trace_valid, trace_pc, trace_seq, i * 4, i);
         else n_pass++;
         tick();
      end
      n_chk++;
      if (trace_valid !== 1'b0)
         $display("FAIL bp_empty: got valid=%b want 0", trace_valid);
      else n_pass++;
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < DEPTH + 3; i++) begin
         commit(32'(i * 4), 32'h13, 5'd2, 32'(i));
         tick();
      end
      idle();
      n_chk++;
      if ({fill_level, overflow, drop_count, retired_count} !== {5'd16, 1'b1, 16'd3, 64'd19})
         $display("FAIL ovf_stats: got fill=%0d ovf=%b drop=%0d ret=%0d want 16/1/3/19",
                  fill_level, overflow, drop_count, retired_count);
      else n_pass++;
      trace_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         n_chk++;
         if ({trace_valid, trace_seq} !== {1'b1, 16'(i)})
            $display("FAIL ovf_drain: got valid=%b seq=%0d want seq=%0d", trace_valid, trace_seq, i);
         else n_pass++;
         tick();
      end
      n_chk++;
      if (trace_valid !== 1'b0)
         $display("FAIL ovf_empty: got valid=%b want 0", trace_valid);
      else n_pass++;
   endtask

   task automatic test_full_push_pop();
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         commit(32'(i * 4), 32'h13, 5'd3, 32'(i));
         tick();
      end
      trace_ready = 1'b1;
      commit(32'h0000_1000, 32'h33, 5'd4, 32'hABCD);
      tick();
      idle();
      trace_ready = 1'b0;
      n_chk++;
      if ({fill_level, drop_count, overflow, trace_seq, trace_pc} !== {5'd16, 16'd0, 1'b0, 16'd1, 32'h4})
         $display("FAIL fpp_stats: got fill=%0d drop=%0d ovf=%b seq=%0d pc=%h want 16/0/0/1/4",
                  fill_level, drop_count, overflow, trace_seq, trace_pc);
      else n_pass++;
      trace_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         n_chk++;
         if ({trace_valid, trace_seq} !== {1'b1, 16'(i + 1)})
            $display("FAIL fpp_drain: got valid=%b seq=%0d want seq=%0d", trace_valid, trace_seq, i + 1);
         else n_pass++;
         if (i == DEPTH - 1) begin
            n_chk++;
            if ({trace_pc, trace_data} !== {32'h0000_1000, 32'hABCD})
               $display("FAIL fpp_tail: got pc=%h data=%h want pc=00001000 data=0000abcd", trace_pc, trace_data);
            else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_flush_clear();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         commit(32'(i * 4), 32'h13, 5'd5, 32'(i));
         tick();
      end
      commit(32'h200, 32'h13, 5'd6, 32'h66);
      flush = 1'b1;
      clear_stats = 1'b1;
      tick();
      idle();
      n_chk++;
      if ({fill_level, trace_valid, drop_count, overflow, retired_count} !== '0)
         $display("FAIL flush_clear: got fill=%0d valid=%b drop=%0d ovf=%b ret=%0d want all 0",
                  fill_level, trace_valid, drop_count, overflow, retired_count);
      else n_pass++;
      commit(32'h300, 32'h13, 5'd7, 32'h77);
      tick();
      idle();
      n_chk++;
      if ({trace_valid, trace_seq, trace_pc, retired_count} !== {1'b1, 16'd6, 32'h300, 64'd1})
         $display("FAIL flush_next_seq: got valid=%b seq=%0d pc=%h ret=%0d want 1/6/300/1",
                  trace_valid, trace_seq, trace_pc, retired_count);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         commit(32'(i * 4), 32'h13, 5'd8, 32'(i));
         tick();
      end
      idle();
      n_chk++;
      if (fill_level !== 5'd8)
         $display("FAIL areset_pre: got fill=%0d want 8", fill_level);
      else n_pass++;
      trace_ready = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({trace_valid, fill_level, overflow, drop_count, retired_count, trace_seq} !== '0)
         $display("FAIL areset_async: got valid=%b fill=%0d ret=%0d want all 0",
                  trace_valid, fill_level, retired_count);
      else n_pass++;
      model_reset();
      rst_n = 1'b1;
      commit(32'h400, 32'h13, 5'd9, 32'h99);
      tick();
      idle();
      n_chk++;
      if ({trace_valid, trace_seq, trace_pc} !== {1'b1, 16'd0, 32'h400})
         $display("FAIL areset_first_seq: got valid=%b seq=%0d pc=%h want 1/0/400",
                  trace_valid, trace_seq, trace_pc);
      else n_pass++;
      tick();
   endtask

   task automatic test_random();
      int rdy_pct;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rdy_pct = ((c / 250) % 2 == 0) ? 25 : 75;
         commit_valid = ($urandom_range(0, 99) < 70);
         commit_pc    = $urandom;
         commit_instr = $urandom;
         commit_rd    = 5'($urandom_range(0, 31));
         commit_data  = $urandom;
         trace_ready  = ($urandom_range(0, 99) < rdy_pct);
         flush        = ($urandom_range(0, 63) == 0);
         clear_stats  = ($urandom_range(0, 79) == 0);
         tick();
         n_chk++;
         if (dut_head() !== exp_head())
            $display("FAIL rand_head cyc=%0d: got %h want %h", c, dut_head(), exp_head());
         else n_pass++;
         n_chk++;
         if ({overflow, drop_count, retired_count, fill_level} !== {m_ovf, m_drop, m_ret, 5'(mq.size())})
            $display("FAIL rand_stats cyc=%0d: got ovf=%b drop=%0d ret=%0d fill=%0d want %b/%0d/%0d/%0d",
                     c, overflow, drop_count, retired_count, fill_level, m_ovf, m_drop, m_ret, mq.size());
         else n_pass++;
      end
      idle();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_record();
      test_backpressure();
      test_overflow();
      test_full_push_pop();
      test_flush_clear();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Sits directly downstream of the core's commit port; captures one record per retired instruction (pc, instr, rd, writeback data).
- Buffers records in a FIFO and drains them to a trace consumer (scoreboard adapter, debug UART, trace DMA) over a valid/ready handshake.
- The core cannot be back-pressured, so this block never stalls the core. It drops records on overflow and reports the loss through sequence numbers, a sticky flag and counters.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- DROP_CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- commit_valid  input  1  one instruction retires this cycle
- commit_pc  input  32  retiring PC
- commit_instr  input  32  retiring instruction word
- commit_rd  input  5  destination register
- commit_data  input  32  writeback data
- trace_valid  output  1  head record available
- trace_ready  input  1  consumer accepts head record
- trace_pc  output  32  head record PC
- trace_instr  output  32  head record instruction
- trace_rd  output  5  head record rd
- trace_data  output  32  head record writeback data
- trace_seq  output  16  head record sequence number
- flush  input  1  synchronous FIFO empty
- clear_stats  input  1  synchronous clear of counters and flag
- overflow  output  1  sticky: at least one record dropped
- drop_count  output  DROP_CNT_W  saturating count of dropped records
- retired_count  output  64  count of all commit_valid cycles
- fill_level  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Clocking and reset: single clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: all outputs 0, FIFO empty, internal sequence counter 0.
- Push: a cycle with commit_valid=1 and flush=0 writes {pc, instr, rd, data, seq} when not full, or when full and a pop happens in the same cycle.
- Sequence counter: increments on every commit_valid=1 cycle, whether written or dropped; wraps 0xFFFF to 0x0000. Gaps in trace_seq therefore expose lost records.
- Pop: occurs on trace_valid && trace_ready.
- trace_valid is exactly !empty.
- While trace_valid=1 and trace_ready=0, all trace_* outputs hold stable.
- Latency: a record pushed in cycle N is visible on trace_* in cycle N+1 at the earliest. There is no same-cycle bypass when the FIFO is empty.
- Drop: commit_valid=1 with the FIFO full and no pop in that cycle.
  - Record discarded.
  - overflow set.
  - drop_count += 1, saturating at all-ones.
- fill_level:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle: unchanged
  - ranges 0..DEPTH
- Pointers are log2(DEPTH) bits plus a wrap bit and wrap naturally. Full means equal index with opposite wrap bit.
- Flush:
  - Next cycle: FIFO empty, fill_level=0, trace_valid=0.
  - A simultaneous commit is discarded but still counted in retired_count and the sequence counter. It does not increment drop_count.
  - A simultaneous pop is ignored.
- clear_stats:
  - Next cycle: overflow=0, drop_count=0, retired_count=0.
  - FIFO contents and the sequence counter are untouched.
  - An event in the same cycle as clear_stats is not counted; clear wins.
- retired_count: increments on every commit_valid=1 cycle; 64-bit, wraps.
- Reset asserted mid-operation: FIFO contents lost immediately; all outputs return to reset values asynchronously.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- Defined:
  - Adds a 32-bit free-running cycle counter (reset 0, increments every cycle, wraps).
  - Its value at push time is stored with each record.
  - Adds output port trace_timestamp (32 bits), stable under the same handshake rules as the other trace_* outputs; reset 0.
- Undefined: no counter, no storage, no trace_timestamp port; all other behaviour identical.

Test Plan:
1. Single record: after reset, commit_valid=1 for one cycle with pc=0x00000010, instr=0x00500093, rd=1, data=5, trace_ready=1 -> next cycle trace_valid=1 with the same fields and trace_seq=0; following cycle trace_valid=0; retired_count=1.
2. Backpressure: trace_ready=0, 3 commits (pc 0x0, 0x4, 0x8) -> fill_level=3, trace_pc holds 0x0 stable. Raise trace_ready -> pcs drained in order 0x0, 0x4, 0x8 with seq 0, 1, 2.
3. Overflow: trace_ready=0, DEPTH+3=19 consecutive commits -> fill_level=16, overflow=1, drop_count=3, retired_count=19. Draining yields seq 0..15 only.
4. Full with simultaneous push and pop: FIFO full, commit_valid=1 and trace_ready=1 in the same cycle -> fill_level stays 16, drop_count unchanged, new record appears at the tail.
5. Flush and clear collision: 5 entries queued; assert flush, clear_stats and commit_valid together -> next cycle fill_level=0, trace_valid=0, drop_count=0, overflow=0, retired_count=0. The next commit carries seq=6.
6. Async reset mid-drain: rst_n low while fill_level=8 -> trace_valid=0, fill_level=0, all counters 0 without waiting for a clock edge. The first commit after release carries seq=0.
